// File: rtl/pong_pkg.sv
// Shared types, defaults and helpers for the pong game controller.
package pong_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2
  } game_state_e;

  localparam int NBALLS_DEF       = 15;
  localparam int LIVES_INIT_DEF   = 3;
  localparam int SERVE_FRAMES_DEF = 60;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/pong_serve_pick.sv
// Lowest-index selector: one-hot grant of the lowest set bit of mask, plus valid.
module pong_serve_pick #(
  parameter int NBALLS = pong_pkg::NBALLS_DEF
) (
  input  logic [NBALLS-1:0] mask,
  output logic [NBALLS-1:0] grant,
  output logic              valid
);

  // Two's-complement isolate of the lowest set bit.
  always_comb begin
    grant = mask & (~mask + NBALLS'(1));
    valid = |mask;
  end

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game controller: frame/start edge detection, game FSM, lives, score,
// per-ball loss tracking and periodic serving of disabled balls.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int NBALLS       = NBALLS_DEF,
  parameter int LIVES_INIT   = LIVES_INIT_DEF,
  parameter int SERVE_FRAMES = SERVE_FRAMES_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              vga_v_sync,
  input  logic              start,
  input  logic [NBALLS-1:0] ball_lost,
  input  logic              paddle_hit,
  output logic [NBALLS-1:0] ball_enable,
  output logic [NBALLS-1:0] ball_respawn,
  output logic [15:0]       score,
  output logic [2:0]        lives,
  output logic [1:0]        game_state
);

  localparam logic [7:0] SERVE_MAX  = 8'(SERVE_FRAMES - 1);
  localparam logic [2:0] LIVES_LOAD = 3'(LIVES_INIT);

  logic vs_q, vs_prev_q, frame_tick_q;
  logic start_q, start_prev_q, armed_q;
  logic vs_fall_s, start_rise_s;

  game_state_e       state_q, state_d;
  logic [NBALLS-1:0] enable_q, enable_d;
  logic [NBALLS-1:0] respawn_q, respawn_d;
  logic [NBALLS-1:0] latch_q, latch_d;
  logic [15:0]       score_q, score_d;
  logic [2:0]        lives_q, lives_d;
  logic [7:0]        serve_cnt_q, serve_cnt_d;

  logic [NBALLS-1:0] live_lost_s, lost_s, cand_s, grant_s;
  logic              grant_vld_s, expire_s;

  assign vs_fall_s    = vs_prev_q & ~vs_q;
  assign start_rise_s = start_q & ~start_prev_q;

  // Until armed, the previous-start flop tracks the raw input so a button
  // held through reset release never looks like a fresh press.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vs_q         <= 1'b0;
      vs_prev_q    <= 1'b0;
      frame_tick_q <= 1'b0;
      start_q      <= 1'b0;
      start_prev_q <= 1'b0;
      armed_q      <= 1'b0;
    end else begin
      vs_q         <= vga_v_sync;
      vs_prev_q    <= vs_q;
      frame_tick_q <= vs_fall_s;
      start_q      <= start;
      start_prev_q <= armed_q ? start_q : start;
      armed_q      <= 1'b1;
    end
  end

  assign live_lost_s = ball_lost & enable_q;
  assign lost_s      = latch_q | live_lost_s;
  assign cand_s      = ~enable_q & ~lost_s;
  assign expire_s    = (serve_cnt_q == SERVE_MAX);

  pong_serve_pick #(.NBALLS(NBALLS)) u_pick (
    .mask  (cand_s),
    .grant (grant_s),
    .valid (grant_vld_s)
  );

  // Next-state logic; a loss restarts the serve period so a just-lost ball
  // waits a full period before it can be served again.
  always_comb begin
    state_d     = state_q;
    enable_d    = enable_q;
    respawn_d   = '0;
    latch_d     = latch_q;
    score_d     = score_q;
    lives_d     = lives_q;
    serve_cnt_d = serve_cnt_q;
    case (state_q)
      ST_IDLE: begin
        enable_d = '0;
        latch_d  = '0;
        if (start_rise_s) begin
          state_d     = ST_PLAY;
          lives_d     = LIVES_LOAD;
          score_d     = 16'd0;
          enable_d    = NBALLS'(1);
          respawn_d   = '1;
          serve_cnt_d = 8'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PLAY: begin
        if (paddle_hit) begin
          score_d = sat_inc16(score_q);
        end else begin
          score_d = score_q;
        end
        if (frame_tick_q) begin
          latch_d     = '0;
          enable_d    = enable_q & ~lost_s;
          respawn_d   = lost_s;
          serve_cnt_d = expire_s ? SERVE_MAX : serve_cnt_q + 8'd1;
          if (lost_s != '0) begin
            serve_cnt_d = 8'd0;
          end else begin
            serve_cnt_d = serve_cnt_d;
          end
          if (expire_s && grant_vld_s) begin
            enable_d    = enable_d | grant_s;
            respawn_d   = respawn_d | grant_s;
            serve_cnt_d = 8'd0;
          end else begin
            enable_d = enable_d;
          end
          if (lost_s != '0) begin
            if (lives_q <= 3'd1) begin
              state_d  = ST_OVER;
              lives_d  = 3'd0;
              enable_d = '0;
            end else begin
              lives_d = lives_q - 3'd1;
            end
          end else begin
            lives_d = lives_q;
          end
        end else begin
          latch_d = latch_q | live_lost_s;
        end
      end
      ST_OVER: begin
        enable_d = '0;
        latch_d  = '0;
        if (start_rise_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_OVER;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        enable_d = '0;
        latch_d  = '0;
      end
    endcase
  end

  // Game state and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      enable_q    <= '0;
      respawn_q   <= '0;
      latch_q     <= '0;
      score_q     <= 16'd0;
      lives_q     <= 3'd0;
      serve_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      enable_q    <= enable_d;
      respawn_q   <= respawn_d;
      latch_q     <= latch_d;
      score_q     <= score_d;
      lives_q     <= lives_d;
      serve_cnt_q <= serve_cnt_d;
    end
  end

  assign ball_enable  = enable_q;
  assign ball_respawn = respawn_q;
  assign score        = score_q;
  assign lives        = lives_q;
  assign game_state   = state_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl: vector table plus hand sequences,
// expectations queued on a scoreboard and compared as outputs settle.
module tb_pong_game_ctrl;

  localparam int NB = 15;
  localparam int SF = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic          vga_v_sync;
  logic          start;
  logic [NB-1:0] ball_lost;
  logic          paddle_hit;
  logic [NB-1:0] ball_enable;
  logic [NB-1:0] ball_respawn;
  logic [15:0]   score;
  logic [2:0]    lives;
  logic [1:0]    game_state;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string         name;
    logic [NB-1:0] en;
    logic [NB-1:0] rsp;
    logic [15:0]   sc;
    logic [2:0]    lv;
    logic [1:0]    st;
  } exp_t;

  typedef struct {
    int            hits;
    logic [NB-1:0] lost;
    exp_t          e;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[15];

  pong_game_ctrl #(.NBALLS(NB), .LIVES_INIT(3), .SERVE_FRAMES(SF)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .vga_v_sync   (vga_v_sync),
    .start        (start),
    .ball_lost    (ball_lost),
    .paddle_hit   (paddle_hit),
    .ball_enable  (ball_enable),
    .ball_respawn (ball_respawn),
    .score        (score),
    .lives        (lives),
    .game_state   (game_state)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit expired, got running, want finished");
    $fatal(1);
  end

  function automatic vec_t mk(string nm, int h, logic [NB-1:0] lost, logic [NB-1:0] en,
                              logic [NB-1:0] rsp, logic [15:0] sc, logic [2:0] lv, logic [1:0] st);
    vec_t v;
    v.hits   = h;
    v.lost   = lost;
    v.e.name = nm;
    v.e.en   = en;
    v.e.rsp  = rsp;
    v.e.sc   = sc;
    v.e.lv   = lv;
    v.e.st   = st;
    return v;
  endfunction

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(string nm, logic [NB-1:0] en, logic [NB-1:0] rsp, logic [15:0] sc,
                      logic [2:0] lv, logic [1:0] st);
    exp_t e;
    e.name = nm;
    e.en   = en;
    e.rsp  = rsp;
    e.sc   = sc;
    e.lv   = lv;
    e.st   = st;
    sb_q.push_back(e);
  endtask

  task automatic check_pop();
    exp_t e;
    n_checks++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard: got empty queue, want an expected record");
    end else begin
      e = sb_q.pop_front();
      if (ball_enable !== e.en || ball_respawn !== e.rsp || score !== e.sc ||
          lives !== e.lv || game_state !== e.st) begin
        n_fail++;
        $display("FAIL %s: got en=%h rsp=%h score=%h lives=%0d state=%0d, want en=%h rsp=%h score=%h lives=%0d state=%0d",
                 e.name, ball_enable, ball_respawn, score, lives, game_state,
                 e.en, e.rsp, e.sc, e.lv, e.st);
      end
    end
  endtask

  // One video frame: vsync falls, tick fires a cycle later, outputs update after it.
  task automatic frame(logic [NB-1:0] lost);
    ball_lost  = lost;
    vga_v_sync = 1'b0;
    cyc(1);
    vga_v_sync = 1'b1;
    cyc(2);
    ball_lost  = '0;
  endtask

  task automatic start_game(string nm);
    start = 1'b1;
    push(nm, 15'h0001, 15'h7FFF, 16'h0000, 3'd3, 2'd1);
    cyc(2);
    check_pop();
    start = 1'b0;
    push({nm, "_rsp_one_cycle"}, 15'h0001, 15'h0000, 16'h0000, 3'd3, 2'd1);
    cyc(1);
    check_pop();
  endtask

  initial begin
    logic [NB-1:0] en_e;
    logic [NB-1:0] prev_e;

    vecs[0]  = mk("f1_hits",     2, 15'h0000, 15'h0001, 15'h0000, 16'd2, 3'd3, 2'd1);
    vecs[1]  = mk("f2",          0, 15'h0000, 15'h0001, 15'h0000, 16'd2, 3'd3, 2'd1);
    vecs[2]  = mk("f3",          0, 15'h0000, 15'h0001, 15'h0000, 16'd2, 3'd3, 2'd1);
    vecs[3]  = mk("f4_serve1",   0, 15'h0000, 15'h0003, 15'h0002, 16'd2, 3'd3, 2'd1);
    vecs[4]  = mk("f5",          1, 15'h0000, 15'h0003, 15'h0000, 16'd3, 3'd3, 2'd1);
    vecs[5]  = mk("f6",          1, 15'h0000, 15'h0003, 15'h0000, 16'd4, 3'd3, 2'd1);
    vecs[6]  = mk("f7",          1, 15'h0000, 15'h0003, 15'h0000, 16'd5, 3'd3, 2'd1);
    vecs[7]  = mk("f8_serve2",   0, 15'h0000, 15'h0007, 15'h0004, 16'd5, 3'd3, 2'd1);
    vecs[8]  = mk("f9_lose0_2",  3, 15'h0005, 15'h0002, 15'h0005, 16'd8, 3'd2, 2'd1);
    vecs[9]  = mk("f10",         0, 15'h0000, 15'h0002, 15'h0000, 16'd8, 3'd2, 2'd1);
    vecs[10] = mk("f11",         0, 15'h0000, 15'h0002, 15'h0000, 16'd8, 3'd2, 2'd1);
    vecs[11] = mk("f12",         0, 15'h0000, 15'h0002, 15'h0000, 16'd8, 3'd2, 2'd1);
    vecs[12] = mk("f13_serve0",  0, 15'h0000, 15'h0003, 15'h0001, 16'd8, 3'd2, 2'd1);
    vecs[13] = mk("f14_lose1",   0, 15'h0002, 15'h0001, 15'h0002, 16'd8, 3'd1, 2'd1);
    vecs[14] = mk("f15_gameover",0, 15'h0001, 15'h0000, 15'h0001, 16'd8, 3'd0, 2'd2);

    rstn       = 1'b0;
    vga_v_sync = 1'b0;
    start      = 1'b1;
    ball_lost  = '0;
    paddle_hit = 1'b0;

    push("reset_values", 15'h0000, 15'h0000, 16'h0000, 3'd0, 2'd0);
    cyc(2);
    check_pop();

    #2;
    rstn = 1'b1;
    push("held_start_no_edge", 15'h0000, 15'h0000, 16'h0000, 3'd0, 2'd0);
    cyc(4);
    check_pop();
    vga_v_sync = 1'b1;
    start      = 1'b0;
    cyc(3);

    start_game("start_game1");

    for (int i = 0; i < 15; i++) begin
      if (vecs[i].hits > 0) begin
        paddle_hit = 1'b1;
        cyc(vecs[i].hits);
        paddle_hit = 1'b0;
      end
      sb_q.push_back(vecs[i].e);
      frame(vecs[i].lost);
      check_pop();
    end

    paddle_hit = 1'b1;
    cyc(3);
    paddle_hit = 1'b0;
    push("over_ignores_hits", 15'h0000, 15'h0000, 16'd8, 3'd0, 2'd2);
    cyc(1);
    check_pop();

    start = 1'b1;
    push("over_to_idle", 15'h0000, 15'h0000, 16'd8, 3'd0, 2'd0);
    cyc(2);
    check_pop();
    start = 1'b0;
    cyc(2);

    start_game("start_game2");

    en_e = 15'h0001;
    for (int k = 1; k < NB; k++) begin
      for (int f = 0; f < SF; f++) frame('0);
      prev_e = en_e;
      en_e   = {en_e[NB-2:0], 1'b1};
      push($sformatf("serve_ball%0d", k), en_e, en_e & ~prev_e, 16'd0, 3'd3, 2'd1);
      check_pop();
    end

    for (int f = 0; f < SF - 1; f++) frame('0);
    push("lose1_at_expiry", 15'h7FFD, 15'h0002, 16'd0, 3'd2, 2'd1);
    frame(15'h0002);
    check_pop();
    for (int f = 1; f < SF; f++) begin
      push($sformatf("ball1_waits_%0d", f), 15'h7FFD, 15'h0000, 16'd0, 3'd2, 2'd1);
      frame('0);
      check_pop();
    end
    push("ball1_reserved", 15'h7FFF, 15'h0002, 16'd0, 3'd2, 2'd1);
    frame('0);
    check_pop();

    paddle_hit = 1'b1;
    cyc(65534);
    paddle_hit = 1'b0;
    push("score_fffe", 15'h7FFF, 15'h0000, 16'hFFFE, 3'd2, 2'd1);
    cyc(1);
    check_pop();
    for (int p = 0; p < 3; p++) begin
      paddle_hit = 1'b1;
      cyc(1);
      paddle_hit = 1'b0;
      cyc(1);
    end
    push("score_saturates", 15'h7FFF, 15'h0000, 16'hFFFF, 3'd2, 2'd1);
    check_pop();

    #2;
    rstn = 1'b0;
    #1;
    push("async_reset_midplay", 15'h0000, 15'h0000, 16'h0000, 3'd0, 2'd0);
    check_pop();
    cyc(2);
    #2;
    rstn = 1'b1;
    push("after_reset_release", 15'h0000, 15'h0000, 16'h0000, 3'd0, 2'd0);
    cyc(3);
    check_pop();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
